uart_2_axi_master: RTL and testbench

UART-to-AXI-lite bridge acting as an AXI4-lite initiator: an external host sends framed byte commands over a UART line, and the block turns them into single AXI-lite read or write transactions. It returns a status byte, plus read data, over the UART TX line. It is the initiator-side counterpart of the AXI-lite slave UART peripheral: it sits between a debug or host UART pin pair and an AXI-lite interconnect port.

---
 rtl/uart_2_axi_pkg.sv | 34 +++
 rtl/uart_byte_phy.sv | 145 ++++++++++++++
 rtl/uart_2_axi_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_2_axi_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_2_axi_pkg.sv
// Shared constants and state encodings for the UART-to-AXI-lite bridge.
package uart_2_axi_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_ERR = 8'h45;
  localparam logic [7:0] ST_UNK = 8'h3F;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_AXI_WR,
    S_AXI_WR_RESP,
    S_AXI_RD,
    S_AXI_RD_RESP,
    S_SEND_RESP
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return (resp == AXI_RESP_OKAY) ? ST_OK : ST_ERR;
  endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 UART byte receiver and transmitter sharing one bit-period setting.
module uart_byte_phy
  import uart_2_axi_pkg::*;
#(
  parameter int clk_frec = 100000000,
  parameter int baudrate = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       rx_vld_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_o
);

  localparam int          BIT_CYC   = clk_frec / baudrate;
  localparam logic [31:0] BIT_LAST  = 32'(BIT_CYC - 1);
  localparam logic [31:0] HALF_LAST = 32'(BIT_CYC / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_st_q, rx_st_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_vld_q, rx_vld_d, rx_ferr_q, rx_ferr_d;

  logic        tx_act_q, tx_act_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_idx_q, tx_idx_d;
  logic [8:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        tx_last;

  assign rx_vld_o  = rx_vld_q;
  assign rx_ferr_o = rx_ferr_q;
  assign rx_data_o = rx_sh_q;
  assign tx_o      = tx_q;

  // The final cycle of a stop bit accepts a new byte so frames run back to back.
  assign tx_last   = tx_act_q && (tx_cnt_q == BIT_LAST) && (tx_idx_q == 4'd9);
  assign tx_busy_o = tx_act_q && !tx_last;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q + 32'd1;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    rx_vld_d  = 1'b0;
    rx_ferr_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d  = '0;
          rx_vld_d  = rx_s2_q;
          rx_ferr_d = !rx_s2_q;
          rx_st_d   = RX_IDLE;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_act_d = tx_act_q;
    tx_cnt_d = tx_act_q ? tx_cnt_q + 32'd1 : '0;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    if (tx_start_i && !tx_busy_o) begin
      tx_act_d = 1'b1;
      tx_cnt_d = '0;
      tx_idx_d = '0;
      tx_sh_d  = {1'b1, tx_data_i};
      tx_d     = 1'b0;
    end else if (tx_act_q && (tx_cnt_q == BIT_LAST)) begin
      tx_cnt_d = '0;
      if (tx_idx_q == 4'd9) begin
        tx_act_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        tx_d     = tx_sh_q[0];
        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
        tx_idx_d = tx_idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      tx_act_q  <= 1'b0;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_sh_q   <= '1;
      tx_q      <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_vld_q  <= rx_vld_d;
      rx_ferr_q <= rx_ferr_d;
      tx_act_q  <= tx_act_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_idx_q  <= tx_idx_d;
      tx_sh_q   <= tx_sh_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_2_axi_master.sv
// UART command decoder driving single AXI4-lite read/write transactions,
// answering with a status byte (plus read data) on the UART TX line.
module uart_2_axi_master
  import uart_2_axi_pkg::*;
#(
  parameter int clk_frec       = 100000000,
  parameter int baudrate       = 9600,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic       rx_vld, rx_ferr, tx_busy, tx_start;
  logic [7:0] rx_data, tx_byte;

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
  logic [31:0] tout_q, tout_d;
  logic [2:0]  tx_idx_q, tx_idx_d, tx_n_q, tx_n_d;

  uart_byte_phy #(
    .clk_frec (clk_frec),
    .baudrate (baudrate)
  ) u_phy (
    .clk_i      (M_AXI_ACLK),
    .rst_i      (M_AXI_ARESET),
    .rx_i       (rx),
    .rx_vld_o   (rx_vld),
    .rx_data_o  (rx_data),
    .rx_ferr_o  (rx_ferr),
    .tx_start_i (tx_start),
    .tx_data_i  (tx_byte),
    .tx_busy_o  (tx_busy),
    .tx_o       (tx)
  );

  assign busy          = (state_q != S_IDLE) || tx_busy;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {4{wvalid_q}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    tout_d    = tout_q + 32'd1;
    tx_idx_d  = tx_idx_q;
    tx_n_d    = tx_n_q;
    tx_start  = 1'b0;
    tx_byte   = ST_UNK;
    case (state_q)
      S_IDLE: begin
        tout_d = '0;
        cnt_d  = '0;
        if (rx_vld) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            state_d = S_GET_ADDR;
            is_wr_d = (rx_data == CMD_WR);
          end else begin
            tx_start = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_ferr) begin
          state_d = S_IDLE;
        end else if (rx_vld) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          tout_d = '0;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = S_GET_DATA;
            end else begin
              state_d   = S_AXI_RD;
              arvalid_d = 1'b1;
            end
          end
        end else if (tout_q == TOUT_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (rx_ferr) begin
          state_d = S_IDLE;
        end else if (rx_vld) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          tout_d  = '0;
          if (cnt_q == 2'd3) begin
            state_d   = S_AXI_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end else if (tout_q == TOUT_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_AXI_WR: begin
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_AXI_WR_RESP;
          bready_d = 1'b1;
        end
      end
      // Status byte launches on the handshake cycle itself; if the TX is
      // still busy it is retried from resp_q in SEND_RESP.
      S_AXI_WR_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d = 1'b0;
          resp_d   = M_AXI_BRESP;
          tx_start = 1'b1;
          tx_byte  = status_byte(M_AXI_BRESP);
          tx_idx_d = tx_busy ? 3'd0 : 3'd1;
          tx_n_d   = 3'd1;
          state_d  = S_SEND_RESP;
        end
      end
      S_AXI_RD: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_AXI_RD_RESP;
        end
      end
      S_AXI_RD_RESP: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d = 1'b0;
          resp_d   = M_AXI_RRESP;
          rdata_d  = M_AXI_RDATA;
          tx_start = 1'b1;
          tx_byte  = status_byte(M_AXI_RRESP);
          tx_idx_d = tx_busy ? 3'd0 : 3'd1;
          tx_n_d   = 3'd5;
          state_d  = S_SEND_RESP;
        end
      end
      S_SEND_RESP: begin
        if (tx_idx_q != tx_n_q) begin
          tx_start = 1'b1;
          case (tx_idx_q)
            3'd0:    tx_byte = status_byte(resp_q);
            3'd1:    tx_byte = rdata_q[31:24];
            3'd2:    tx_byte = rdata_q[23:16];
            3'd3:    tx_byte = rdata_q[15:8];
            default: tx_byte = rdata_q[7:0];
          endcase
          if (!tx_busy) tx_idx_d = tx_idx_q + 3'd1;
        end else if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      tout_q    <= '0;
      tx_idx_q  <= '0;
      tx_n_q    <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      tout_q    <= tout_d;
      tx_idx_q  <= tx_idx_d;
      tx_n_q    <= tx_n_d;
    end
  end

endmodule

// File: tb/tb_uart_2_axi_master.sv
// Directed bench: UART host driver, TX byte monitor and AXI-lite slave model.
module tb_uart_2_axi_master;

  localparam int BIT  = 10;
  localparam int TOUT = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        tx, busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = 32'h0;

  int          aw_delay = 0, w_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_vld_cyc = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  int          ws_c;
  bit          ws_aw_done, ws_w_done;
  logic [7:0]  mon_b;
  logic [7:0]  txq[$];
  int          n_pass = 0, n_chk = 0, n_fail = 0;

  uart_2_axi_master #(
    .clk_frec       (1000),
    .baudrate       (100),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .rx            (rx),
    .tx            (tx),
    .busy          (busy),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_msg(input logic [71:0] msg, input int n);
    for (int i = 0; i < n; i++) send_byte(msg[8 * (n - 1 - i) +: 8], 1'b1);
  endtask

  task automatic wait_tx(input string tag, input int n);
    int t;
    t = 0;
    while (txq.size() < n && t < BIT * 12 * (n + 1) + 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(txq.size()), 32'(n));
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    v = 8'hxx;
    if (txq.size() > 0) v = txq.pop_front();
    check(tag, {24'h0, v}, {24'h0, exp});
  endtask

  // UART TX monitor: samples each bit at its midpoint.
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        txq.push_back(mon_b);
      end
    end
  end

  // AXI-lite write slave with per-channel ready delays.
  initial begin
    forever begin
      @(negedge clk);
      if (M_AXI_AWVALID || M_AXI_WVALID) begin
        ws_c = 0;
        ws_aw_done = 1'b0;
        ws_w_done = 1'b0;
        while (!(ws_aw_done && ws_w_done)) begin
          M_AXI_AWREADY = !ws_aw_done && (ws_c >= aw_delay);
          M_AXI_WREADY  = !ws_w_done && (ws_c >= w_delay);
          @(posedge clk);
          if (M_AXI_AWVALID) aw_vld_cyc++;
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            ws_aw_done = 1'b1;
            aw_cnt++;
            cap_awaddr = M_AXI_AWADDR;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            ws_w_done = 1'b1;
            w_cnt++;
            cap_wdata = M_AXI_WDATA;
            cap_wstrb = M_AXI_WSTRB;
          end
          @(negedge clk);
          ws_c++;
        end
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b1;
        M_AXI_BRESP   = bresp_cfg;
        @(posedge clk);
        while (!M_AXI_BREADY) @(posedge clk);
        @(negedge clk);
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
      end
    end
  end

  // AXI-lite read slave.
  initial begin
    forever begin
      @(negedge clk);
      if (M_AXI_ARVALID) begin
        M_AXI_ARREADY = 1'b1;
        @(posedge clk);
        if (M_AXI_ARVALID) begin
          ar_cnt++;
          cap_araddr = M_AXI_ARADDR;
        end
        @(negedge clk);
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b1;
        M_AXI_RDATA   = rdata_cfg;
        M_AXI_RRESP   = 2'b00;
        @(posedge clk);
        while (!M_AXI_RREADY) @(posedge clk);
        @(negedge clk);
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = 32'h0;
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_vld_rdy", {27'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                          M_AXI_BREADY, M_AXI_RREADY}, 32'h0);
    check("rst_awaddr", M_AXI_AWADDR, 32'h0);
    check("rst_wdata", M_AXI_WDATA, 32'h0);
    check("rst_wstrb", {28'h0, M_AXI_WSTRB}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain write
    send_byte(8'h57, 1'b1);
    check("wr1_busy", {31'h0, busy}, 32'h1);
    send_msg(72'h00000008DEADBEEF, 8);
    wait_tx("wr1_nbytes", 1);
    expect_byte("wr1_status", 8'h4B);
    check("wr1_aw_cnt", aw_cnt, 1);
    check("wr1_w_cnt", w_cnt, 1);
    check("wr1_awaddr", cap_awaddr, 32'h8);
    check("wr1_wdata", cap_wdata, 32'hDEADBEEF);
    check("wr1_wstrb", {28'h0, cap_wstrb}, 32'hF);
    repeat (2 * BIT) @(negedge clk);
    check("wr1_idle", {31'h0, busy}, 32'h0);

    // Plain read
    rdata_cfg = 32'h12345678;
    send_msg(72'h5200000004, 5);
    wait_tx("rd1_nbytes", 5);
    expect_byte("rd1_status", 8'h4B);
    expect_byte("rd1_d3", 8'h12);
    expect_byte("rd1_d2", 8'h34);
    expect_byte("rd1_d1", 8'h56);
    expect_byte("rd1_d0", 8'h78);
    check("rd1_ar_cnt", ar_cnt, 1);
    check("rd1_araddr", cap_araddr, 32'h4);
    repeat (2 * BIT) @(negedge clk);

    // Write with AWREADY 20 cycles after WREADY and SLVERR
    aw_delay = 20;
    bresp_cfg = 2'b10;
    aw_vld_cyc = 0;
    send_msg(72'h570000002000000001, 9);
    wait_tx("wr2_nbytes", 1);
    expect_byte("wr2_status", 8'h45);
    check("wr2_aw_held", aw_vld_cyc, 21);
    check("wr2_aw_cnt", aw_cnt, 2);
    check("wr2_awaddr", cap_awaddr, 32'h20);
    aw_delay = 0;
    bresp_cfg = 2'b00;
    repeat (2 * BIT) @(negedge clk);

    // Unknown command byte
    send_byte(8'h33, 1'b1);
    wait_tx("unk_nbytes", 1);
    expect_byte("unk_status", 8'h3F);
    check("unk_no_aw", aw_cnt, 2);
    check("unk_no_ar", ar_cnt, 1);
    repeat (2 * BIT) @(negedge clk);
    check("unk_idle", {31'h0, busy}, 32'h0);

    // Inter-byte timeout, then a normal read
    send_msg(72'h570000, 3);
    repeat (TOUT + 100) @(negedge clk);
    check("tout_idle", {31'h0, busy}, 32'h0);
    check("tout_no_tx", 32'(txq.size()), 32'h0);
    rdata_cfg = 32'hA5A50F0F;
    send_msg(72'h5200000000, 5);
    wait_tx("tout_rd_nbytes", 5);
    expect_byte("tout_rd_status", 8'h4B);
    expect_byte("tout_rd_d3", 8'hA5);
    expect_byte("tout_rd_d2", 8'hA5);
    expect_byte("tout_rd_d1", 8'h0F);
    expect_byte("tout_rd_d0", 8'h0F);
    check("tout_no_aw", aw_cnt, 2);
    check("tout_ar_cnt", ar_cnt, 2);
    check("tout_araddr", cap_araddr, 32'h0);
    repeat (2 * BIT) @(negedge clk);

    // Framing error in the address phase aborts silently
    send_msg(72'h5200, 2);
    send_byte(8'h11, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("ferr_no_tx", 32'(txq.size()), 32'h0);
    check("ferr_idle", {31'h0, busy}, 32'h0);
    check("ferr_no_ar", ar_cnt, 2);
    send_msg(72'h5700000010CAFEF00D, 9);
    wait_tx("ferr_wr_nbytes", 1);
    expect_byte("ferr_wr_status", 8'h4B);
    check("ferr_wr_aw_cnt", aw_cnt, 3);
    check("ferr_wr_awaddr", cap_awaddr, 32'h10);
    check("ferr_wr_wdata", cap_wdata, 32'hCAFEF00D);
    check("ferr_wr_no_ar", ar_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
